// File: rtl/nth_prime_seeker.sv
// rtl/nth_prime_seeker.sv - walks candidates through an external primality tester and returns the Nth prime
// Optional feature macro: NTH_PRIME_SKIP_EVEN_EN (skip even candidates above 2)
module nth_prime_seeker #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             valid,
  output logic             err,
  output logic [WIDTH-1:0] prime,
  output logic [WIDTH-1:0] tests,
  output logic             t_start,
  output logic [WIDTH-1:0] t_value,
  input  logic             t_result,
  input  logic             t_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOW, S_HIGH, S_ARM, S_WAIT, S_EVAL, S_FIN
  } state_t;

  localparam logic [WIDTH-1:0] CAND_MAX = '1;
  localparam logic [WIDTH-1:0] CAND_TWO = WIDTH'(2);

  state_t           state;
  logic [WIDTH-1:0] n_lat;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] found;
  logic             res;
  logic             fail;
  logic [WIDTH-1:0] cand_next;
  logic             at_limit;
  logic [WIDTH-1:0] found_sum;

`ifdef NTH_PRIME_SKIP_EVEN_EN
  assign cand_next = (cand == CAND_TWO) ? WIDTH'(3) : cand + WIDTH'(2);
  assign at_limit  = (cand >= CAND_MAX - WIDTH'(1));
`else
  assign cand_next = cand + WIDTH'(1);
  assign at_limit  = (cand == CAND_MAX);
`endif

  assign found_sum = found + WIDTH'(res);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      valid   <= 1'b0;
      err     <= 1'b0;
      prime   <= '0;
      tests   <= '0;
      t_start <= 1'b0;
      t_value <= '0;
      n_lat   <= '0;
      cand    <= '0;
      found   <= '0;
      res     <= 1'b0;
      fail    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        S_IDLE: begin
          t_start <= 1'b0;
          if (req) begin
            prime <= '0;
            tests <= '0;
            err   <= 1'b0;
            if (n == '0) begin
              fail  <= 1'b1;
              state <= S_FIN;
            end else begin
              n_lat   <= n;
              cand    <= CAND_TWO;
              t_value <= CAND_TWO;
              found   <= '0;
              fail    <= 1'b0;
              busy    <= 1'b1;
              state   <= S_LOW;
            end
          end
        end
        S_LOW: begin
          t_start <= 1'b1;
          tests   <= tests + WIDTH'(1);
          state   <= S_HIGH;
        end
        S_HIGH: state <= S_ARM;
        // A t_done left high by the previous transaction must fall before a new one counts.
        S_ARM: if (!t_done) state <= S_WAIT;
        S_WAIT: begin
          if (t_done) begin
            res     <= t_result;
            t_start <= 1'b0;
            state   <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (res) found <= found_sum;
          if (found_sum == n_lat) begin
            state <= S_FIN;
          end else if (at_limit) begin
            fail  <= 1'b1;
            state <= S_FIN;
          end else begin
            cand    <= cand_next;
            t_value <= cand_next;
            state   <= S_LOW;
          end
        end
        S_FIN: begin
          valid <= 1'b1;
          busy  <= 1'b0;
          err   <= fail;
          prime <= fail ? '0 : cand;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
